// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Serves RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against a small RAM.
// The top 16 bytes form an MMIO window: CYCLE, STORES, SCRATCH and STATUS.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous reset, active-low
//   MemRead  - load request this cycle
//   MemWrite - store request this cycle (wins over MemRead)
//   addr     - byte address
//   wr_data  - store data; the store size takes its low bits
//   func3    - RV32I funct3 of the access
//   rd_data  - extended load data, combinational (0 on no load or on error)
//   acc_err  - combinational error pulse for the current access
//   led_out  - scratch[7:0]
module dmem_responder #(
  parameter int unsigned              DM_ADDRESS = 9,
  parameter int unsigned              DATA_W     = 32,  // only 32 is supported
  // Must be 16-byte aligned: MMIO registers are selected by addr[3:2].
  parameter logic [DM_ADDRESS-1:0]    MMIO_BASE  = 9'h1F0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  acc_err,
  output logic [7:0]            led_out
);

  localparam int unsigned RamWords = 32'(MMIO_BASE) >> 2;

  logic [31:0] mem [RamWords];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] scratch_q, scratch_d;
  logic        err_flag_q, err_flag_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic                  is_store, is_load, is_mmio;
  logic                  f3_bad, misalign, mmio_bad;
  logic                  st_ok, ram_we, status_clr;
  logic [1:0]            mmio_sel;
  logic [DM_ADDRESS-3:0] word_idx;
  logic [3:0]            be;
  logic [31:0]           wlane, word_rd, mmio_word;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  // A store takes priority when both strobes are high.
  assign is_store = MemWrite;
  assign is_load  = MemRead & ~MemWrite;
  assign is_mmio  = (addr >= MMIO_BASE);
  assign mmio_sel = addr[3:2];
  assign word_idx = addr[DM_ADDRESS-1:2];

  // Error classification.
  always_comb begin
    f3_bad = 1'b0;
    if (is_store) begin
      f3_bad = (func3 >= 3'b011);
    end else if (is_load) begin
      f3_bad = (func3 == 3'b011) || (func3[2:1] == 2'b11);
    end
    misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
               ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    mmio_bad = is_mmio && (func3[1:0] != 2'b10);
    acc_err  = (is_store || is_load) && (f3_bad || misalign || mmio_bad);
  end

  assign st_ok      = is_store & ~acc_err;
  assign ram_we     = st_ok & ~is_mmio;
  assign status_clr = st_ok && is_mmio && (mmio_sel == 2'd3) && wr_data[0];

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wlane = wr_data;
    case (func3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wr_data[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // MMIO next state. Error set and status clear cannot coincide: the clear is a legal access.
  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    stores_d   = st_ok ? stores_q + 32'd1 : stores_q;
    scratch_d  = (st_ok && is_mmio && (mmio_sel == 2'd2)) ? wr_data : scratch_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (acc_err) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (status_clr) begin
      err_flag_d = 1'b0;
      err_cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q    <= '0;
      stores_q   <= '0;
      scratch_q  <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      cycle_q    <= cycle_d;
      stores_q   <= stores_d;
      scratch_q  <= scratch_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Read path.
  always_comb begin
    case (mmio_sel)
      2'd0:    mmio_word = cycle_q;
      2'd1:    mmio_word = stores_q;
      2'd2:    mmio_word = scratch_q;
      default: mmio_word = {16'h0000, err_cnt_q, 7'b0000000, err_flag_q};
    endcase
    word_rd = is_mmio ? mmio_word : mem[word_idx];
    byte_v  = word_rd[{addr[1:0], 3'b000} +: 8];
    half_v  = addr[1] ? word_rd[31:16] : word_rd[15:0];
    rd_data = '0;
    if (is_load && !acc_err) begin
      case (func3)
        3'b000:  rd_data = {{24{byte_v[7]}}, byte_v};
        3'b001:  rd_data = {{16{half_v[15]}}, half_v};
        3'b010:  rd_data = word_rd;
        3'b100:  rd_data = {24'h000000, byte_v};
        3'b101:  rd_data = {16'h0000, half_v};
        default: rd_data = '0;
      endcase
    end
  end

  assign led_out = scratch_q[7:0];

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [8:0] A_CYC = 9'h1F0, A_STO = 9'h1F4, A_SCR = 9'h1F8, A_STA = 9'h1FC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] rd_data;
  logic        acc_err;
  logic [7:0]  led_out;

  int checks = 0;
  int failures = 0;
  int stores_m = 0;  // model of accepted stores since reset

  typedef struct {logic [31:0] d; logic e;} exp_t;
  typedef struct {
    logic rd; logic wr; logic [8:0] a; logic [31:0] wd; logic [2:0] f3;
    logic [31:0] ed; logic ee; string nm;
  } op_t;

  exp_t exp_q[$];

  dmem_responder dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .wr_data(wr_data), .func3(func3), .rd_data(rd_data), .acc_err(acc_err), .led_out(led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic op_t ld(logic [2:0] f3, logic [8:0] a, logic [31:0] ed, logic ee, string nm);
    op_t o = '{1'b1, 1'b0, a, 32'h0, f3, ed, ee, nm};
    return o;
  endfunction

  function automatic op_t st(logic [2:0] f3, logic [8:0] a, logic [31:0] wd, logic ee, string nm);
    op_t o = '{1'b0, 1'b1, a, wd, f3, 32'h0, ee, nm};
    return o;
  endfunction

  // Drive at negedge, push the expectation, sample mid-phase, let the posedge commit.
  task automatic access(input op_t o, output logic [31:0] d, output logic e);
    @(negedge clk);
    MemRead = o.rd; MemWrite = o.wr; addr = o.a; wr_data = o.wd; func3 = o.f3;
    exp_q.push_back('{o.ed, o.ee});
    if (o.wr && !o.ee) stores_m++;
    #1;
    d = rd_data;
    e = acc_err;
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    stores_m = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    op_t ops[$];
    logic [31:0] gd; logic ge; exp_t ex;
    #3;
    checks++;
    if (led_out !== 8'h00) begin
      failures++; $display("FAIL reset_led: led_out=%h required 00", led_out);
    end
    release_reset();
    ops.push_back(ld(LW, A_STO, 32'h0, 1'b0, "rst_stores"));
    ops.push_back(ld(LW, A_SCR, 32'h0, 1'b0, "rst_scratch"));
    ops.push_back(ld(LW, A_STA, 32'h0, 1'b0, "rst_status"));
    foreach (ops[i]) begin
      access(ops[i], gd, ge);
      ex = exp_q.pop_front();
      checks++;
      if (gd !== ex.d || ge !== ex.e) begin
        failures++;
        $display("FAIL %s: rd_data=%h acc_err=%b required %h/%b", ops[i].nm, gd, ge, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_ram_access();
    op_t ops[$]; op_t o;
    logic [31:0] gd; logic ge; exp_t ex;
    ops.push_back(st(SW, 9'h010, 32'hDEADBEEF, 1'b0, "sw_010"));
    ops.push_back(ld(LW, 9'h010, 32'hDEADBEEF, 1'b0, "lw_010"));
    ops.push_back(ld(LB, 9'h013, 32'hFFFFFFDE, 1'b0, "lb_013"));
    ops.push_back(ld(LBU, 9'h013, 32'h000000DE, 1'b0, "lbu_013"));
    ops.push_back(st(SB, 9'h011, 32'hFFFFFF55, 1'b0, "sb_011"));
    ops.push_back(ld(LW, 9'h010, 32'hDEAD55EF, 1'b0, "lw_after_sb"));
    ops.push_back(st(SH, 9'h012, 32'h12348001, 1'b0, "sh_012"));
    ops.push_back(ld(LH, 9'h012, 32'hFFFF8001, 1'b0, "lh_012"));
    ops.push_back(ld(LHU, 9'h012, 32'h00008001, 1'b0, "lhu_012"));
    ops.push_back(ld(LW, 9'h010, 32'h800155EF, 1'b0, "lw_after_sh"));
    ops.push_back(ld(LB, 9'h010, 32'hFFFFFFEF, 1'b0, "lb_010"));
    ops.push_back(ld(LBU, 9'h011, 32'h00000055, 1'b0, "lbu_011"));
    ops.push_back(ld(LH, 9'h010, 32'h000055EF, 1'b0, "lh_010"));
    o = st(SW, 9'h014, 32'h11223344, 1'b0, "rd_wr_both"); o.rd = 1'b1;
    ops.push_back(o);
    ops.push_back(ld(LW, 9'h014, 32'h11223344, 1'b0, "lw_014"));
    foreach (ops[i]) begin
      access(ops[i], gd, ge);
      ex = exp_q.pop_front();
      checks++;
      if (gd !== ex.d || ge !== ex.e) begin
        failures++;
        $display("FAIL %s: rd_data=%h acc_err=%b required %h/%b", ops[i].nm, gd, ge, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_errors();
    op_t ops[$]; op_t o;
    logic [31:0] gd; logic ge; exp_t ex;
    ops.push_back(st(SW, 9'h020, 32'hCAFEF00D, 1'b0, "sw_020"));
    ops.push_back(st(SW, 9'h022, 32'h12345678, 1'b1, "sw_mis_022"));
    ops.push_back(ld(LW, 9'h020, 32'hCAFEF00D, 1'b0, "ram_unchanged"));
    ops.push_back(ld(LW, A_STA, 32'h00000101, 1'b0, "status_1"));
    ops.push_back(ld(LH, 9'h011, 32'h0, 1'b1, "lh_mis_011"));
    ops.push_back(ld(LW, A_STA, 32'h00000201, 1'b0, "status_2"));
    ops.push_back(ld(3'b011, 9'h010, 32'h0, 1'b1, "ld_f3_011"));
    ops.push_back(ld(3'b110, 9'h010, 32'h0, 1'b1, "ld_f3_110"));
    ops.push_back(ld(3'b111, 9'h010, 32'h0, 1'b1, "ld_f3_111"));
    ops.push_back(st(3'b011, 9'h010, 32'h0, 1'b1, "st_f3_011"));
    ops.push_back(st(3'b100, 9'h010, 32'h0, 1'b1, "st_f3_100"));
    ops.push_back(ld(LW, 9'h010, 32'h800155EF, 1'b0, "ram_kept_bad_st"));
    ops.push_back(ld(LB, A_SCR, 32'h0, 1'b1, "mmio_lb"));
    ops.push_back(st(SB, A_SCR, 32'hFF, 1'b1, "mmio_sb"));
    ops.push_back(ld(LHU, A_STA, 32'h0, 1'b1, "mmio_lhu"));
    ops.push_back(ld(LW, A_STA, 32'h00000A01, 1'b0, "status_10"));
    o = ld(LW, 9'h010, 32'h0, 1'b0, "idle_no_read"); o.rd = 1'b0;
    ops.push_back(o);
    ops.push_back(st(SW, A_STA, 32'hFFFFFFFE, 1'b0, "status_wr0"));
    ops.push_back(ld(LW, A_STA, 32'h00000A01, 1'b0, "status_kept"));
    ops.push_back(st(SW, A_STA, 32'h00000001, 1'b0, "status_clr"));
    ops.push_back(ld(LW, A_STA, 32'h0, 1'b0, "status_cleared"));
    foreach (ops[i]) begin
      access(ops[i], gd, ge);
      ex = exp_q.pop_front();
      checks++;
      if (gd !== ex.d || ge !== ex.e) begin
        failures++;
        $display("FAIL %s: rd_data=%h acc_err=%b required %h/%b", ops[i].nm, gd, ge, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_err_saturate();
    logic [31:0] gd; logic ge; exp_t ex; op_t o;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      o = ld(LW, 9'h011, 32'h0, 1'b1, "sat_mis");
      access(o, gd, ge);
      ex = exp_q.pop_front();
      checks++;
      if (gd !== ex.d || ge !== ex.e) begin
        failures++; bad++;
        if (bad < 4)
          $display("FAIL sat_mis[%0d]: rd_data=%h acc_err=%b required %h/%b", i, gd, ge, ex.d, ex.e);
      end
    end
    o = ld(LW, A_STA, 32'h0000FF01, 1'b0, "status_sat");
    access(o, gd, ge);
    ex = exp_q.pop_front();
    checks++;
    if (gd !== ex.d || ge !== ex.e) begin
      failures++;
      $display("FAIL %s: rd_data=%h acc_err=%b required %h/%b", o.nm, gd, ge, ex.d, ex.e);
    end
    access(st(SW, A_STA, 32'h1, 1'b0, "clr"), gd, ge);
    void'(exp_q.pop_front());
  endtask

  task automatic test_mmio();
    logic [31:0] gd; logic ge; exp_t ex; op_t o;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: o = st(SW, A_SCR, 32'h000000A5, 1'b0, "sw_scratch_a5");
        1: o = ld(LW, A_SCR, 32'h000000A5, 1'b0, "lw_scratch_a5");
        2: o = ld(LW, A_STO, 32'(stores_m), 1'b0, "stores_count");
        3: o = st(SW, A_CYC, 32'h0, 1'b0, "sw_cycle_ignored");
        4: o = st(SW, A_STO, 32'h12345678, 1'b0, "sw_stores_self");
        5: o = ld(LW, A_STO, 32'(stores_m), 1'b0, "stores_after_self");
        6: o = st(SW, A_SCR, 32'hFFFFFF3C, 1'b0, "sw_scratch_3c");
        7: o = st(SH, A_SCR, 32'h0, 1'b1, "sh_scratch_err");
        8: o = ld(LW, A_SCR, 32'hFFFFFF3C, 1'b0, "scratch_kept");
        default: o = ld(LW, A_STA, 32'h00000101, 1'b0, "status_after_mmio_err");
      endcase
      access(o, gd, ge);
      ex = exp_q.pop_front();
      checks++;
      if (gd !== ex.d || ge !== ex.e) begin
        failures++;
        $display("FAIL %s: rd_data=%h acc_err=%b required %h/%b", o.nm, gd, ge, ex.d, ex.e);
      end
      if (i == 0) begin
        checks++;
        if (led_out !== 8'hA5) begin
          failures++; $display("FAIL led_a5: led_out=%h required a5", led_out);
        end
      end
    end
    checks++;
    if (led_out !== 8'h3C) begin
      failures++; $display("FAIL led_3c: led_out=%h required 3c", led_out);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] gd; logic ge; exp_t ex; op_t o;
    pulse_reset();
    release_reset();
    repeat (19) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = ld(LW, A_CYC, 32'(20 + i), 1'b0, "cycle_read");
      access(o, gd, ge);
      ex = exp_q.pop_front();
      checks++;
      if (gd !== ex.d || ge !== ex.e) begin
        failures++;
        $display("FAIL %s[%0d]: rd_data=%h acc_err=%b required %h/%b", o.nm, i, gd, ge, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    logic [31:0] gd; logic ge; exp_t ex;
    access(st(SW, A_SCR, 32'h5A, 1'b0, "pre"), gd, ge);
    void'(exp_q.pop_front());
    pulse_reset();
    checks++;
    if (led_out !== 8'h00) begin
      failures++; $display("FAIL async_reset_led: led_out=%h required 00", led_out);
    end
    release_reset();
    ops.push_back(ld(LW, 9'h010, 32'h800155EF, 1'b0, "ram_kept_010"));
    ops.push_back(ld(LW, 9'h014, 32'h11223344, 1'b0, "ram_kept_014"));
    ops.push_back(ld(LW, 9'h020, 32'hCAFEF00D, 1'b0, "ram_kept_020"));
    ops.push_back(ld(LW, A_STO, 32'h0, 1'b0, "stores_reset"));
    ops.push_back(ld(LW, A_SCR, 32'h0, 1'b0, "scratch_reset"));
    ops.push_back(ld(LW, A_STA, 32'h0, 1'b0, "status_reset"));
    foreach (ops[i]) begin
      access(ops[i], gd, ge);
      ex = exp_q.pop_front();
      checks++;
      if (gd !== ex.d || ge !== ex.e) begin
        failures++;
        $display("FAIL %s: rd_data=%h acc_err=%b required %h/%b", ops[i].nm, gd, ge, ex.d, ex.e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_access();
    test_errors();
    test_err_saturate();
    test_mmio();
    test_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
